// File: rtl/soc_bus_arbiter_if.sv
// Shared SoC system bus bundle: CPU and DMA master ports, shared slave bus
// and the error reporting lines to the interrupt controller.
//   slave  modport : the arbiter's view (answers the masters, drives the slave bus)
//   master modport : the view of the surrounding SoC (masters, slaves, INTC)
interface soc_bus_arbiter_if #(
   parameter int unsigned NUM_SLAVES = 6,
   parameter int unsigned ERR_CNT_W  = 8
);
   logic                       cpu_m_req;
   logic [31:0]                cpu_m_addr;
   logic                       cpu_m_wr_en;
   logic [31:0]                cpu_m_wdata;
   logic                       cpu_m_gnt;
   logic [31:0]                cpu_m_rdata;

   logic                       dma_m_req;
   logic [31:0]                dma_m_addr;
   logic                       dma_m_wr_en;
   logic [31:0]                dma_m_wdata;
   logic                       dma_m_gnt;
   logic [31:0]                dma_m_rdata;

   logic [31:0]                s_addr;
   logic                       s_wr_en;
   logic [31:0]                s_wdata;
   logic [NUM_SLAVES-1:0]      s_sel;
   logic [NUM_SLAVES*32-1:0]   s_rdata;

   logic                       err_clr;
   logic                       bus_err_irq;
   logic [ERR_CNT_W-1:0]       err_count;

   modport slave (
      input  cpu_m_req, cpu_m_addr, cpu_m_wr_en, cpu_m_wdata,
      output cpu_m_gnt, cpu_m_rdata,
      input  dma_m_req, dma_m_addr, dma_m_wr_en, dma_m_wdata,
      output dma_m_gnt, dma_m_rdata,
      output s_addr, s_wr_en, s_wdata, s_sel,
      input  s_rdata,
      input  err_clr,
      output bus_err_irq, err_count
   );

   modport master (
      output cpu_m_req, cpu_m_addr, cpu_m_wr_en, cpu_m_wdata,
      input  cpu_m_gnt, cpu_m_rdata,
      output dma_m_req, dma_m_addr, dma_m_wr_en, dma_m_wdata,
      input  dma_m_gnt, dma_m_rdata,
      input  s_addr, s_wr_en, s_wdata, s_sel,
      output s_rdata,
      output err_clr,
      input  bus_err_irq, err_count
   );
endinterface

// File: rtl/soc_bus_arbiter.sv
// Responder side of the shared SoC bus: round-robin CPU/DMA arbitration with
// registered grants, owner datapath mux, one-hot address decode, read return
// with a built-in default slave, grant timeout and illegal-access reporting.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : soc_bus_arbiter_if.slave (master ports, shared slave bus, error lines)
module soc_bus_arbiter #(
   parameter int unsigned NUM_SLAVES     = 6,
   parameter logic [31:0] DEFAULT_RDATA  = 32'h0BAD_DDAA,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned ERR_CNT_W      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   soc_bus_arbiter_if.slave bus
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned REGION_W = 16;
   localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DMA} state_t;

   state_t                state;
   logic                  last_dma;
   logic                  cpu_gnt;
   logic                  dma_gnt;
   logic [CNT_W-1:0]      cnt;
   logic                  blk_cpu;
   logic                  blk_dma;
   logic [DATA_W-1:0]     prev_addr;
   logic [ERR_CNT_W-1:0]  err_count_q;
   logic                  irq_q;

   logic                  granted;
   logic [DATA_W-1:0]     own_addr;
   logic [DATA_W-1:0]     own_wdata;
   logic                  own_wr_en;
   logic [REGION_W-1:0]   region;
   logic                  mapped;
   logic [NUM_SLAVES-1:0] sel;
   logic [DATA_W-1:0]     own_rdata;
   logic                  illegal_start;
   logic                  timeout;
   logic                  cpu_elig;
   logic                  dma_elig;

   // Owner mux: everything reads zero while nobody holds the bus
   always_comb begin
      own_addr  = '0;
      own_wdata = '0;
      own_wr_en = 1'b0;
      if (cpu_gnt) begin
         own_addr  = bus.cpu_m_addr;
         own_wdata = bus.cpu_m_wdata;
         own_wr_en = bus.cpu_m_wr_en;
      end else if (dma_gnt) begin
         own_addr  = bus.dma_m_addr;
         own_wdata = bus.dma_m_wdata;
         own_wr_en = bus.dma_m_wr_en;
      end
   end

   assign granted = cpu_gnt | dma_gnt;
   assign region  = own_addr[DATA_W-1:REGION_W];
   assign mapped  = granted && (region < REGION_W'(NUM_SLAVES));

   // Decode and read return; unmapped granted accesses hit the default slave
   always_comb begin
      sel       = '0;
      own_rdata = granted ? DEFAULT_RDATA : '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (mapped && (region == REGION_W'(k))) begin
            sel[k]    = 1'b1;
            own_rdata = bus.s_rdata[k*DATA_W +: DATA_W];
         end
      end
   end

   // A new illegal access: first granted cycle, or the address moved
   assign illegal_start = granted && !mapped && ((cnt == '0) || (own_addr != prev_addr));
   assign timeout = ((state == OWN_CPU && bus.cpu_m_req) || (state == OWN_DMA && bus.dma_m_req))
                    && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign cpu_elig = bus.cpu_m_req && !blk_cpu;
   assign dma_elig = bus.dma_m_req && !blk_dma;

   // Arbitration FSM, grant counter and error bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_dma    <= 1'b1;
         cpu_gnt     <= 1'b0;
         dma_gnt     <= 1'b0;
         cnt         <= '0;
         blk_cpu     <= 1'b0;
         blk_dma     <= 1'b0;
         prev_addr   <= '0;
         err_count_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         prev_addr <= own_addr;
         if (illegal_start && (err_count_q != {ERR_CNT_W{1'b1}}))
            err_count_q <= err_count_q + ERR_CNT_W'(1);
         // A new error outranks a simultaneous clear
         if (illegal_start || timeout)
            irq_q <= 1'b1;
         else if (bus.err_clr)
            irq_q <= 1'b0;
         if (!bus.cpu_m_req) blk_cpu <= 1'b0;
         if (!bus.dma_m_req) blk_dma <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (cpu_elig && (!dma_elig || last_dma)) begin
                  state   <= OWN_CPU;
                  cpu_gnt <= 1'b1;
               end else if (dma_elig) begin
                  state   <= OWN_DMA;
                  dma_gnt <= 1'b1;
               end
            end
            OWN_CPU: begin
               if (!bus.cpu_m_req || timeout) begin
                  state    <= IDLE;
                  cpu_gnt  <= 1'b0;
                  last_dma <= 1'b0;
                  if (timeout) blk_cpu <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            OWN_DMA: begin
               if (!bus.dma_m_req || timeout) begin
                  state    <= IDLE;
                  dma_gnt  <= 1'b0;
                  last_dma <= 1'b1;
                  if (timeout) blk_dma <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               cpu_gnt <= 1'b0;
               dma_gnt <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_m_gnt   = cpu_gnt;
   assign bus.dma_m_gnt   = dma_gnt;
   assign bus.cpu_m_rdata = cpu_gnt ? own_rdata : '0;
   assign bus.dma_m_rdata = dma_gnt ? own_rdata : '0;
   assign bus.s_addr      = own_addr;
   assign bus.s_wdata     = own_wdata;
   // Writes to unmapped space are dropped
   assign bus.s_wr_en     = own_wr_en && mapped;
   assign bus.s_sel       = sel;
   assign bus.bus_err_irq = irq_q;
   assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Self-checking bench for soc_bus_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the bus rules.
module tb_soc_bus_arbiter;

   localparam int unsigned NS = 6;
   localparam int unsigned EW = 8;
   localparam int unsigned TO = 1024;
   localparam logic [31:0] DEF = 32'h0BAD_DDAA;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   soc_bus_arbiter_if #(.NUM_SLAVES(NS), .ERR_CNT_W(EW)) bus ();

   soc_bus_arbiter #(
      .NUM_SLAVES(NS), .DEFAULT_RDATA(DEF), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(EW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   // Slave side: region 0 is a small RAM, other regions return a fixed tag
   logic [31:0]      ram [256];
   logic [NS*32-1:0] srd;
   always_comb begin
      for (int k = 0; k < NS; k++) srd[k*32 +: 32] = 32'hA5A5_0000 | 32'(k);
      srd[31:0] = ram[bus.s_addr[9:2]];
   end
   assign bus.s_rdata = srd;
   always @(posedge clk) if (bus.s_wr_en && bus.s_sel[0]) ram[bus.s_addr[9:2]] <= bus.s_wdata;

   // Behavioural model: owner 0 = none, 1 = CPU, 2 = DMA
   int          m_owner, m_last, m_held, m_err;
   bit          m_irq, m_blk_cpu, m_blk_dma;
   logic [31:0] m_prev;

   function automatic logic [31:0] slave_val(input logic [31:0] a);
      if (a[31:16] == 16'd0) return ram[a[9:2]];
      return 32'hA5A5_0000 | 32'(a[31:16]);
   endfunction

   function void model_reset();
      m_owner = 0; m_last = 2; m_held = 0; m_err = 0;
      m_irq = 0; m_blk_cpu = 0; m_blk_dma = 0; m_prev = '0;
   endfunction

   function void model_edge();
      logic [31:0] a;
      bit rq, unm, ill, to, ce, de;
      a   = (m_owner == 1) ? bus.cpu_m_addr : (m_owner == 2) ? bus.dma_m_addr : 32'd0;
      rq  = (m_owner == 1) ? bus.cpu_m_req : (m_owner == 2) ? bus.dma_m_req : 1'b0;
      unm = (m_owner != 0) && (int'(a[31:16]) >= NS);
      ill = unm && (m_held == 0 || a != m_prev);
      to  = (m_owner != 0) && rq && (m_held == TO - 1);
      m_prev = a;
      if (ill && m_err < 255) m_err++;
      if (ill || to) m_irq = 1;
      else if (bus.err_clr) m_irq = 0;
      if (!bus.cpu_m_req) m_blk_cpu = 0;
      if (!bus.dma_m_req) m_blk_dma = 0;
      if (m_owner != 0) begin
         if (!rq || to) begin
            if (to && m_owner == 1) m_blk_cpu = 1;
            if (to && m_owner == 2) m_blk_dma = 1;
            m_last = m_owner; m_owner = 0;
         end else m_held++;
      end else begin
         ce = bus.cpu_m_req && !m_blk_cpu;
         de = bus.dma_m_req && !m_blk_dma;
         if (ce && de) m_owner = (m_last == 1) ? 2 : 1;
         else if (ce) m_owner = 1;
         else if (de) m_owner = 2;
         m_held = 0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_m_req = 0; bus.cpu_m_addr = '0; bus.cpu_m_wr_en = 0; bus.cpu_m_wdata = '0;
      bus.dma_m_req = 0; bus.dma_m_addr = '0; bus.dma_m_wr_en = 0; bus.dma_m_wdata = '0;
      bus.err_clr = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      #2;
      tests++; if (bus.cpu_m_gnt !== 1'b0 || bus.dma_m_gnt !== 1'b0) begin fails++;
         $display("FAIL reset_gnt: got %b/%b expected 0/0", bus.cpu_m_gnt, bus.dma_m_gnt); end
      apply_reset();
      tests++; if (bus.s_sel !== 6'b0 || bus.s_addr !== 32'd0 || bus.s_wr_en !== 1'b0) begin fails++;
         $display("FAIL reset_bus: sel %b addr %h wr %b expected all 0", bus.s_sel, bus.s_addr, bus.s_wr_en); end
      tests++; if (bus.err_count !== 8'd0 || bus.bus_err_irq !== 1'b0) begin fails++;
         $display("FAIL reset_err: cnt %0d irq %b expected 0/0", bus.err_count, bus.bus_err_irq); end
      tests++; if (bus.cpu_m_rdata !== 32'd0 || bus.dma_m_rdata !== 32'd0) begin fails++;
         $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.cpu_m_rdata, bus.dma_m_rdata); end
   endtask

   task automatic test_cpu_write_read();
      apply_reset();
      bus.cpu_m_req = 1; bus.cpu_m_addr = 32'h0000_0010; bus.cpu_m_wr_en = 1; bus.cpu_m_wdata = 32'h1234_5678;
      #1;
      tests++; if (bus.cpu_m_gnt !== 1'b0) begin fails++;
         $display("FAIL wr_gnt_latency: got %b expected 0", bus.cpu_m_gnt); end
      tick();
      tests++; if (bus.cpu_m_gnt !== 1'b1) begin fails++;
         $display("FAIL wr_gnt: got %b expected 1", bus.cpu_m_gnt); end
      tests++; if (bus.s_sel !== 6'b000001 || bus.s_wr_en !== 1'b1) begin fails++;
         $display("FAIL wr_sel: sel %b wr %b expected 000001/1", bus.s_sel, bus.s_wr_en); end
      tests++; if (bus.s_addr !== 32'h0000_0010 || bus.s_wdata !== 32'h1234_5678) begin fails++;
         $display("FAIL wr_data: addr %h data %h expected 00000010/12345678", bus.s_addr, bus.s_wdata); end
      tick();
      bus.cpu_m_wr_en = 0;
      #1;
      tests++; if (bus.cpu_m_rdata !== 32'h1234_5678 || bus.s_wr_en !== 1'b0) begin fails++;
         $display("FAIL rd_back: rdata %h wr %b expected 12345678/0", bus.cpu_m_rdata, bus.s_wr_en); end
      tests++; if (bus.dma_m_rdata !== 32'd0) begin fails++;
         $display("FAIL rd_nonowner: got %h expected 0", bus.dma_m_rdata); end
      bus.cpu_m_req = 0;
      tick();
      tests++; if (bus.cpu_m_gnt !== 1'b0) begin fails++;
         $display("FAIL wr_release: got %b expected 0", bus.cpu_m_gnt); end
   endtask

   task automatic test_contention();
      apply_reset();
      bus.cpu_m_req = 1; bus.dma_m_req = 1;
      bus.dma_m_addr = 32'h0002_0000;
      tick();
      tests++; if (bus.cpu_m_gnt !== 1'b1 || bus.dma_m_gnt !== 1'b0) begin fails++;
         $display("FAIL cont_first: got %b/%b expected 1/0", bus.cpu_m_gnt, bus.dma_m_gnt); end
      tick();
      bus.cpu_m_req = 0;
      tick();
      tests++; if (bus.cpu_m_gnt !== 1'b0 || bus.dma_m_gnt !== 1'b0) begin fails++;
         $display("FAIL cont_gap: got %b/%b expected 0/0", bus.cpu_m_gnt, bus.dma_m_gnt); end
      tick();
      tests++; if (bus.dma_m_gnt !== 1'b1 || bus.s_sel !== 6'b000100) begin fails++;
         $display("FAIL cont_dma: gnt %b sel %b expected 1/000100", bus.dma_m_gnt, bus.s_sel); end
      tests++; if (bus.dma_m_rdata !== 32'hA5A5_0002 || bus.cpu_m_rdata !== 32'd0) begin fails++;
         $display("FAIL cont_rdata: dma %h cpu %h expected a5a50002/0", bus.dma_m_rdata, bus.cpu_m_rdata); end
      bus.dma_m_req = 0;
      tick();
      bus.cpu_m_req = 1; bus.dma_m_req = 1;
      tick();
      tests++; if (bus.cpu_m_gnt !== 1'b1 || bus.dma_m_gnt !== 1'b0) begin fails++;
         $display("FAIL cont_rr: got %b/%b expected 1/0", bus.cpu_m_gnt, bus.dma_m_gnt); end
      idle_inputs();
      tick();
   endtask

   task automatic test_illegal();
      apply_reset();
      bus.cpu_m_req = 1; bus.cpu_m_addr = 32'h9000_0000;
      tick();
      tests++; if (bus.cpu_m_rdata !== DEF || bus.s_sel !== 6'b0) begin fails++;
         $display("FAIL ill_rdata: rdata %h sel %b expected %h/0", bus.cpu_m_rdata, bus.s_sel, DEF); end
      tick();
      tests++; if (bus.err_count !== 8'd1 || bus.bus_err_irq !== 1'b1) begin fails++;
         $display("FAIL ill_err: cnt %0d irq %b expected 1/1", bus.err_count, bus.bus_err_irq); end
      tick();
      tests++; if (bus.err_count !== 8'd1) begin fails++;
         $display("FAIL ill_hold: cnt %0d expected 1", bus.err_count); end
      bus.err_clr = 1;
      tick();
      bus.err_clr = 0;
      tests++; if (bus.bus_err_irq !== 1'b0) begin fails++;
         $display("FAIL ill_clr: irq %b expected 0", bus.bus_err_irq); end
      // Clear and new error in the same cycle: set wins
      bus.cpu_m_addr = 32'h9000_0004; bus.err_clr = 1;
      tick();
      bus.err_clr = 0;
      tests++; if (bus.bus_err_irq !== 1'b1 || bus.err_count !== 8'd2) begin fails++;
         $display("FAIL ill_setwins: irq %b cnt %0d expected 1/2", bus.bus_err_irq, bus.err_count); end
      idle_inputs();
      tick();
   endtask

   task automatic test_timeout();
      int dma_cycles, drop_at, cpu_at;
      logic irq_at_drop;
      dma_cycles = 0; drop_at = 0; cpu_at = 0; irq_at_drop = 0;
      apply_reset();
      bus.dma_m_req = 1; bus.dma_m_addr = 32'h0001_0000;
      for (int i = 1; i <= 1100; i++) begin
         if (i == 5) bus.cpu_m_req = 1;
         tick();
         if (bus.dma_m_gnt) dma_cycles++;
         if (!bus.dma_m_gnt && drop_at == 0 && dma_cycles > 0) begin
            drop_at = i; irq_at_drop = bus.bus_err_irq;
         end
         if (bus.cpu_m_gnt && cpu_at == 0) cpu_at = i;
      end
      tests++; if (dma_cycles != 1024 || drop_at != 1025) begin fails++;
         $display("FAIL to_len: granted %0d drop %0d expected 1024/1025", dma_cycles, drop_at); end
      tests++; if (irq_at_drop !== 1'b1 || bus.err_count !== 8'd0) begin fails++;
         $display("FAIL to_irq: irq %b cnt %0d expected 1/0", irq_at_drop, bus.err_count); end
      tests++; if (cpu_at != 1026) begin fails++;
         $display("FAIL to_cpu: cpu granted at %0d expected 1026", cpu_at); end
      bus.cpu_m_req = 0;
      tick();
      tick();
      tick();
      tests++; if (bus.dma_m_gnt !== 1'b0) begin fails++;
         $display("FAIL to_blocked: dma gnt %b expected 0", bus.dma_m_gnt); end
      bus.dma_m_req = 0;
      tick();
      bus.dma_m_req = 1;
      tick();
      tests++; if (bus.dma_m_gnt !== 1'b1) begin fails++;
         $display("FAIL to_unblock: dma gnt %b expected 1", bus.dma_m_gnt); end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_grant();
      apply_reset();
      bus.cpu_m_req = 1; bus.cpu_m_addr = 32'h9000_0000;
      tick();
      tick();
      bus.cpu_m_addr = 32'h0000_0020; bus.cpu_m_wr_en = 1; bus.cpu_m_wdata = 32'hCAFE_F00D;
      #1;
      tests++; if (bus.cpu_m_gnt !== 1'b1 || bus.s_sel !== 6'b000001 || bus.s_wr_en !== 1'b1 || bus.err_count !== 8'd1) begin
         fails++;
         $display("FAIL mid_pre: gnt %b sel %b wr %b cnt %0d expected 1/000001/1/1",
                  bus.cpu_m_gnt, bus.s_sel, bus.s_wr_en, bus.err_count);
      end
      rst_n = 0;
      #1;
      tests++; if (bus.cpu_m_gnt !== 1'b0 || bus.s_sel !== 6'b0 || bus.s_wr_en !== 1'b0 || bus.err_count !== 8'd0) begin
         fails++;
         $display("FAIL mid_async: gnt %b sel %b wr %b cnt %0d expected 0/0/0/0",
                  bus.cpu_m_gnt, bus.s_sel, bus.s_wr_en, bus.err_count);
      end
      apply_reset();
   endtask

   task automatic test_saturation();
      int wr_seen;
      wr_seen = 0;
      apply_reset();
      bus.cpu_m_req = 1; bus.cpu_m_addr = 32'h9000_0000;
      tick();
      for (int i = 1; i < 300; i++) begin
         bus.cpu_m_addr = 32'h9000_0000 + 32'(i * 4);
         tick();
      end
      tick();
      tests++; if (bus.err_count !== 8'd255) begin fails++;
         $display("FAIL sat_count: got %0d expected 255", bus.err_count); end
      bus.cpu_m_addr = 32'h0006_0000; bus.cpu_m_wr_en = 1; bus.cpu_m_wdata = 32'h5555_AAAA;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (bus.s_wr_en || bus.s_sel != '0) wr_seen++;
         tick();
      end
      tests++; if (wr_seen != 0 || bus.cpu_m_rdata !== DEF) begin fails++;
         $display("FAIL unmapped_wr: pulses %0d rdata %h expected 0/%h", wr_seen, bus.cpu_m_rdata, DEF); end
      tests++; if (bus.err_count !== 8'd255) begin fails++;
         $display("FAIL sat_nowrap: got %0d expected 255", bus.err_count); end
      bus.cpu_m_addr = 32'h0005_0000;
      #1;
      tests++; if (bus.s_sel !== 6'b100000 || bus.s_wr_en !== 1'b1) begin fails++;
         $display("FAIL top_region: sel %b wr %b expected 100000/1", bus.s_sel, bus.s_wr_en); end
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      logic [31:0] e_addr, e_wdata, e_rd;
      logic        e_wr, e_map;
      logic [5:0]  e_sel;
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) bus.cpu_m_req = ~bus.cpu_m_req;
         if ($urandom_range(0, 7) == 0) bus.dma_m_req = ~bus.dma_m_req;
         if ($urandom_range(0, 1) == 0)
            bus.cpu_m_addr = {16'($urandom_range(0, 8)), 16'($urandom_range(0, 3) * 4)};
         if ($urandom_range(0, 1) == 0)
            bus.dma_m_addr = {16'($urandom_range(0, 8)), 16'($urandom_range(0, 3) * 4)};
         bus.cpu_m_wr_en = 1'($urandom_range(0, 1));
         bus.dma_m_wr_en = 1'($urandom_range(0, 1));
         bus.cpu_m_wdata = $urandom;
         bus.dma_m_wdata = $urandom;
         bus.err_clr = ($urandom_range(0, 15) == 0);
         #1;
         e_addr  = (m_owner == 1) ? bus.cpu_m_addr : (m_owner == 2) ? bus.dma_m_addr : 32'd0;
         e_wdata = (m_owner == 1) ? bus.cpu_m_wdata : (m_owner == 2) ? bus.dma_m_wdata : 32'd0;
         e_map   = (m_owner != 0) && (int'(e_addr[31:16]) < NS);
         e_sel   = e_map ? 6'(1 << e_addr[31:16]) : 6'd0;
         e_wr    = e_map && ((m_owner == 1) ? bus.cpu_m_wr_en : bus.dma_m_wr_en);
         e_rd    = (m_owner == 0) ? 32'd0 : e_map ? slave_val(e_addr) : DEF;
         tests++; if (bus.cpu_m_gnt !== (m_owner == 1) || bus.dma_m_gnt !== (m_owner == 2)) begin fails++;
            $display("FAIL rnd_gnt c%0d: got %b/%b expected owner %0d", c, bus.cpu_m_gnt, bus.dma_m_gnt, m_owner); end
         tests++; if (bus.s_addr !== e_addr || bus.s_wdata !== e_wdata) begin fails++;
            $display("FAIL rnd_mux c%0d: addr %h data %h expected %h/%h", c, bus.s_addr, bus.s_wdata, e_addr, e_wdata); end
         tests++; if (bus.s_sel !== e_sel || bus.s_wr_en !== e_wr) begin fails++;
            $display("FAIL rnd_dec c%0d: sel %b wr %b expected %b/%b", c, bus.s_sel, bus.s_wr_en, e_sel, e_wr); end
         tests++; if (bus.cpu_m_rdata !== ((m_owner == 1) ? e_rd : 32'd0) ||
                      bus.dma_m_rdata !== ((m_owner == 2) ? e_rd : 32'd0)) begin fails++;
            $display("FAIL rnd_rdata c%0d: cpu %h dma %h expected %h for owner %0d",
                     c, bus.cpu_m_rdata, bus.dma_m_rdata, e_rd, m_owner); end
         tests++; if (int'(bus.err_count) != m_err || bus.bus_err_irq !== m_irq) begin fails++;
            $display("FAIL rnd_err c%0d: cnt %0d irq %b expected %0d/%b", c, bus.err_count, bus.bus_err_irq, m_err, m_irq); end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_cpu_write_read();
      test_contention();
      test_illegal();
      test_timeout();
      test_reset_mid_grant();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
- Responder side of the shared SoC system bus; the end that answers master requests.
- Arbitrates the two bus masters, CPU and DMA, using the req/gnt handshake.
- Muxes the owning master's address, write enable and write data onto the shared slave bus, decodes the address into one-hot slave selects, and returns read data.
- Unmapped addresses are answered by a built-in default slave; bus errors and stuck owners are flagged to the interrupt controller.

Parameters:
- NUM_SLAVES, 6: number of mapped regions. Region k selected when addr[31:16] == k, for k = 0..NUM_SLAVES-1 (RAM, DMA, CRC, INTC, TIMER, UART).
- DEFAULT_RDATA, 32'h0BAD_DDAA: read data returned for unmapped addresses.
- TIMEOUT_CYCLES, 1024: maximum number of consecutive granted cycles before forced release.
- ERR_CNT_W, 8: width of the illegal-access counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_m_req  in  1  CPU bus request
- cpu_m_addr  in  32  CPU address
- cpu_m_wr_en  in  1  CPU write enable
- cpu_m_wdata  in  32  CPU write data
- cpu_m_gnt  out  1  CPU grant
- cpu_m_rdata  out  32  CPU read data
- dma_m_req  in  1  DMA bus request
- dma_m_addr  in  32  DMA address
- dma_m_wr_en  in  1  DMA write enable
- dma_m_wdata  in  32  DMA write data
- dma_m_gnt  out  1  DMA grant
- dma_m_rdata  out  32  DMA read data
- s_addr  out  32  shared slave address
- s_wr_en  out  1  shared slave write strobe
- s_wdata  out  32  shared slave write data
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_rdata  in  NUM_SLAVES*32  slave read data; slice k belongs to region k
- err_clr  in  1  clears bus_err_irq
- bus_err_irq  out  1  sticky bus-error flag to the INTC
- err_count  out  ERR_CNT_W  saturating illegal-access count

Behaviour:
- Reset (async, rst_n low): all outputs and registers go to 0, state = IDLE, last_owner = DMA (so the CPU wins the first tie). Reset mid-grant drops gnt immediately.
- FSM states: IDLE, OWN_CPU, OWN_DMA.
- IDLE, no request: stay in IDLE.
- IDLE, one eligible request: go to that master's OWN state.
- IDLE, both requesting: round-robin; the master that is not last_owner wins.
- Grant latency: gnt is registered. It rises on the edge after the request is sampled and mirrors the OWN state.
- OWN_x holds while x_req = 1. When x_req is sampled 0, return to IDLE and set last_owner = x. gnt falls the next cycle, so there is at least one idle cycle between owners.
- Grant counter:
  - Clears on entry to an OWN state and increments each cycle in it.
  - On reaching TIMEOUT_CYCLES-1: force return to IDLE and set bus_err_irq.
  - The offending master is blocked (not eligible in IDLE) until its req is sampled 0. The other master may be granted meanwhile.
- Datapath (combinational from owner):
  - s_addr, s_wdata = owner's addr/wdata. s_wr_en = owner's wr_en AND gnt.
  - In IDLE: s_addr = 0, s_wdata = 0, s_wr_en = 0, s_sel = 0.
- Decode: s_sel[k] = 1 iff granted and addr[31:16] == k. At most one bit is set.
- Read return:
  - Owner's rdata = s_rdata slice k when selected, else DEFAULT_RDATA when granted with no region matched.
  - Non-owner rdata = 0.
  - rdata is valid in the same cycle as the address; masters sample on the next edge.
- Illegal access:
  - An illegal access starts when granted, no region matched, and either this is the first granted cycle or the address changed from the previous cycle.
  - On each start: err_count increments (saturates at all-ones, no wrap) and bus_err_irq is set.
  - Writes to unmapped space are dropped: s_wr_en = 0 and s_sel = 0.
- bus_err_irq is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, the set wins.
- err_count clears only on reset.

Test Plan:
- CPU-only write/read:
  - CPU req at cycle 0 → cpu_m_gnt = 1 at cycle 1.
  - Write addr 0x0000_0010 data 0x1234_5678 → s_sel = 6'b000001, s_wr_en = 1.
  - Read back → cpu_m_rdata = 0x1234_5678.
- Contention: cpu_m_req and dma_m_req rise in the same cycle after reset:
  - CPU granted first.
  - After CPU drops req: one idle cycle, then DMA granted.
  - After DMA drops and both re-request: CPU granted.
- Illegal read at 0x9000_0000:
  - cpu_m_rdata = 0x0BAD_DDAA, s_sel = 0, err_count = 1, bus_err_irq = 1.
  - err_clr pulse → bus_err_irq = 0.
- Timeout: DMA holds req for 1100 cycles:
  - dma_m_gnt drops after 1024 granted cycles and bus_err_irq = 1.
  - A pending cpu_m_req is granted next.
  - DMA is not re-granted until its req goes low.
- Reset mid-grant: assert rst_n low while OWN_CPU → cpu_m_gnt, s_sel, s_wr_en and err_count go to 0 immediately, without waiting for a clock edge.
- Saturation: 300 distinct illegal addresses → err_count = 255. Also writes to 0x0006_0000 with NUM_SLAVES = 6 → no s_wr_en pulse.
